// File: rtl/fifo_yumi_gather_pkg.sv
// Shared types for the valid-yumi gather block: the two-state bundle FSM encoding.
package fifo_types;

  typedef enum logic [0:0] {
    GATHER_FILL,
    GATHER_HOLD
  } gather_state_e;

endpackage

// File: rtl/fifo_yumi_gather.sv
// Drains words from an upstream valid-yumi FIFO, packs els_p of them (or fewer on
// flush) into one wide bundle, and offers it downstream on a valid-ready port.
module fifo_yumi_gather
  import fifo_types::*;
#(
  parameter int width_p     = 8,
  parameter int els_p       = 4,
  parameter int cnt_width_p = $clog2(els_p + 1)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       valid_i,
  input  logic [width_p-1:0]         data_i,
  output logic                       yumi_o,
  input  logic                       flush_i,
  output logic                       valid_o,
  output logic [width_p*els_p-1:0]   data_o,
  output logic [cnt_width_p-1:0]     count_o,
  input  logic                       ready_i
);

  localparam logic [cnt_width_p-1:0] full_cnt = cnt_width_p'(els_p);
  localparam logic [cnt_width_p-1:0] one_cnt  = cnt_width_p'(1);

  gather_state_e             state_q, state_d;
  logic [cnt_width_p-1:0]    cnt_q, cnt_d;
  logic [cnt_width_p-1:0]    count_q, count_d;
  logic [width_p-1:0]        lane_q [els_p];
  logic [width_p-1:0]        lane_d [els_p];
  logic [cnt_width_p-1:0]    cnt_inc;
  logic                      yumi;

  // Valid-yumi rule: only consume a word we can store this very cycle.
  assign yumi = valid_i & ~reset_i &
                ((state_q == GATHER_FILL) | ((state_q == GATHER_HOLD) & ready_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    lane_d  = lane_q;
    cnt_inc = cnt_q;
    case (state_q)
      GATHER_FILL: begin
        if (yumi) begin
          for (int k = 0; k < els_p; k++) begin
            if (cnt_width_p'(k) == cnt_q) lane_d[k] = data_i;
          end
          cnt_inc = cnt_q + one_cnt;
        end
        // A flush closes the bundle only if at least one word ends up in it.
        if ((cnt_inc == full_cnt) || (flush_i && (cnt_inc != '0))) begin
          state_d = GATHER_HOLD;
          count_d = cnt_inc;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      GATHER_HOLD: begin
        if (ready_i) begin
          state_d = GATHER_FILL;
          count_d = '0;
          for (int k = 0; k < els_p; k++) lane_d[k] = '0;
          if (yumi) begin
            lane_d[0] = data_i;
            cnt_d     = one_cnt;
          end else begin
            cnt_d = '0;
          end
        end
      end
      default: begin
        state_d = GATHER_FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= GATHER_FILL;
      cnt_q   <= '0;
      count_q <= '0;
      for (int k = 0; k < els_p; k++) lane_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      lane_q  <= lane_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_pack
      assign data_o[gi*width_p +: width_p] = lane_q[gi];
    end
  endgenerate

  assign yumi_o  = yumi;
  assign valid_o = (state_q == GATHER_HOLD);
  assign count_o = count_q;

endmodule
